atm_fsm: RTL and testbench
==========================

Name: atm_fsm

Overview:
Session controller for a 5-account ATM. It walks a card session through these steps:
- card detect
- language capture
- card/PIN authentication
- a menu loop serving balance, deposit, withdraw and exit requests

It holds the account balance table internally. It drives per-transaction accept pulses and the displayed balance of the active account.

Parameters:
NUM_ACCOUNTS, 5, valid card numbers 1..NUM_ACCOUNTS
INIT_BALANCE, 1000, balance loaded into every account on reset
MAX_TXN, 2000, maximum single deposit/withdraw amount (inclusive)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous reset, active-high
language_selected  input  1  language choice (0 English, 1 Arabic); latched only, no functional effect
card_inserted  input  1  card present
request  input  2  0 balance inquiry, 1 deposit, 2 withdraw, 3 exit
deposit_value  input  12  deposit amount, unsigned
withdraw_value  input  12  withdraw amount, unsigned
CardNo  input  3  card/account number
Password  input  3  entered PIN
deposit_accepted  output  1  one-cycle pulse, deposit committed
withdraw_accepted  output  1  one-cycle pulse, withdraw committed
balance_displayed  output  18  balance of the authenticated account

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset (rst=1 at posedge):
  - state=IDLE
  - deposit_accepted=0, withdraw_accepted=0, balance_displayed=0
  - all balances=INIT_BALANCE
  - latched card and language cleared
  - reset mid-session aborts with no commit.
- All outputs are registered.
- Account table:
  - 5 entries of 18 bits, index CardNo 1..5.
  - Stored PIN of card k = k.
  - CardNo 0, 6, 7 are invalid.
- State IDLE: card_inserted=1 -> LANG, else stay.
- State LANG: latch language_selected -> AUTH (1 cycle).
- State AUTH:
  - CardNo in 1..5 and Password==stored PIN -> latch CardNo, go MENU.
  - Otherwise go IDLE; balance_displayed stays 0.
- Session timing: from the first posedge with card_inserted=1 in IDLE, MENU is reached after 3 posedges.
- State MENU: balance_displayed=balance[card]. Sample request:
  - request 0 -> stay MENU, refresh display.
  - request 1 -> DEP.
  - request 2 -> WDR.
  - request 3 -> IDLE; clear display and latched card.
- State DEP (1 cycle):
  - Accept iff 1<=deposit_value<=MAX_TXN and balance+deposit_value<=2^18-1.
  - Accept: balance+=value, deposit_accepted=1 for this cycle.
  - Reject: balance unchanged, pulse stays 0.
  - Always return to MENU.
- State WDR (1 cycle):
  - Accept iff 1<=withdraw_value<=MAX_TXN and withdraw_value<=balance.
  - Accept: balance-=value, withdraw_accepted=1 for this cycle.
  - Reject: no change.
  - Always return to MENU.
- balance_displayed updates in the same cycle as a committed transaction.
- Each request therefore takes 2 cycles (MENU then DEP/WDR). A request held for 2 cycles is processed exactly once.
- A request still held on the next MENU cycle is processed again.
- Only request selects the operation; the value of the unselected operation is ignored.
- Accept pulses are never asserted together and are 0 in every other state.
- Arithmetic: 18-bit unsigned, zero-extend the 12-bit inputs. There is no wrap-around, because overflowing deposits are rejected.
- Balances persist across sessions until rst.
- card_inserted is sampled only in IDLE; removal mid-session is ignored until exit.

Test Plan:
1. Card 2, PIN 2, each request held 2 cycles:
   - deposit 1000 -> accept, balance 2000
   - withdraw 800 -> 1200
   - withdraw 700 -> 500
   - deposit 500 -> 1000
   - withdraw 600 -> 400
   - each accept is a single 1-cycle pulse
2. Card 3:
   - deposit 100 -> 1100
   - withdraw 1500 -> withdraw_accepted=0, balance stays 1100
3. Card 4:
   - deposit 3000 -> rejected
   - withdraw 2500 -> rejected
   - deposit 4000 -> rejected
   - balance_displayed 1000 throughout, no pulses
4. Card 6, PIN 6 (invalid):
   - FSM returns to IDLE
   - deposit 500 request -> no pulse, balance_displayed=0
5. Card 1 with Password 2 -> auth fails, IDLE, display 0. Then card 1 PIN 1, request 0 -> display 1000, no pulses.
6. Card 1 session:
   - deposit 500 -> 1500, then request 3 -> display 0, IDLE
   - new session on card 1 -> display 1500
   - assert rst mid-session -> all outputs 0, balance reinitialised to 1000

Source files
------------

// File: rtl/atm_fsm_if.sv
// ---------------------------------------------------------------------------
// atm_fsm_if
// Groups the ATM session controller's card/request inputs and its
// accept/balance outputs into one bundle.
//   master : drives the card, PIN, language and request fields, and observes
//            the accept pulses and the displayed balance (terminal side).
//   slave  : the session controller itself.
// Signals:
//   language_selected  1  language choice (0 English, 1 Arabic)
//   card_inserted      1  card present
//   request            2  0 balance, 1 deposit, 2 withdraw, 3 exit
//   deposit_value     12  deposit amount, unsigned
//   withdraw_value    12  withdraw amount, unsigned
//   CardNo             3  card/account number
//   Password           3  entered PIN
//   deposit_accepted   1  one-cycle pulse, deposit committed
//   withdraw_accepted  1  one-cycle pulse, withdraw committed
//   balance_displayed 18  balance of the authenticated account
// ---------------------------------------------------------------------------
interface atm_fsm_if;
  logic        language_selected;
  logic        card_inserted;
  logic [1:0]  request;
  logic [11:0] deposit_value;
  logic [11:0] withdraw_value;
  logic [2:0]  CardNo;
  logic [2:0]  Password;
  logic        deposit_accepted;
  logic        withdraw_accepted;
  logic [17:0] balance_displayed;

  modport master (
    output language_selected, card_inserted, request,
           deposit_value, withdraw_value, CardNo, Password,
    input  deposit_accepted, withdraw_accepted, balance_displayed
  );

  modport slave (
    input  language_selected, card_inserted, request,
           deposit_value, withdraw_value, CardNo, Password,
    output deposit_accepted, withdraw_accepted, balance_displayed
  );
endinterface

// File: rtl/atm_fsm.sv
// ---------------------------------------------------------------------------
// atm_fsm
// Session controller for a small ATM. It walks a card session through card
// detect, language capture, card/PIN authentication and a menu loop that
// serves balance, deposit, withdraw and exit requests. The per-account
// balance table lives inside this block and survives across sessions until
// reset.
// Ports:
//   clk  in   system clock, every update on the rising edge
//   rst  in   synchronous active-high reset
//   bus  slave side of atm_fsm_if (request inputs, accept pulses and
//        the displayed balance; all outputs are registered)
// ---------------------------------------------------------------------------
module atm_fsm #(
  parameter int NUM_ACCOUNTS = 5,
  parameter int INIT_BALANCE = 1000,
  parameter int MAX_TXN      = 2000
) (
  input logic       clk,
  input logic       rst,
  atm_fsm_if.slave  bus
);

  localparam logic [2:0]  MaxCard = 3'(NUM_ACCOUNTS);
  localparam logic [11:0] MaxTxn  = 12'(MAX_TXN);
  localparam logic [17:0] InitBal = 18'(INIT_BALANCE);

  typedef enum logic [2:0] {
    IDLE,
    LANG,
    AUTH,
    MENU,
    DEP,
    WDR
  } state_t;

  state_t      state_q;
  logic [2:0]  cardNo_q;
  logic [17:0] balance_q [1:NUM_ACCOUNTS];
  logic        depAccepted_q;
  logic        wdrAccepted_q;
  logic [17:0] display_q;
  // The language choice is recorded for the session but nothing downstream
  // consumes it yet.
  logic        unusedLanguage_q;

  logic [17:0] curBalance;
  logic [18:0] depSum;
  logic [17:0] wdrDiff;
  logic        depOk;
  logic        wdrOk;
  logic        authOk;

  // Balance of the latched card. A latched card of 0 (no session) selects
  // nothing and reads as zero.
  always_comb begin
    curBalance = '0;
    for (int k = 1; k <= NUM_ACCOUNTS; k++) begin
      if (cardNo_q == 3'(k)) begin
        curBalance = balance_q[k];
      end
    end
  end

  // Transaction legality. The deposit sum carries one extra bit so that an
  // overflow past 18 bits is detected and the deposit is refused, rather
  // than wrapping around.
  always_comb begin
    depSum  = {1'b0, curBalance} + {7'd0, bus.deposit_value};
    wdrDiff = curBalance - {6'd0, bus.withdraw_value};
    depOk   = (bus.deposit_value != 12'd0) && (bus.deposit_value <= MaxTxn)
              && !depSum[18];
    wdrOk   = (bus.withdraw_value != 12'd0) && (bus.withdraw_value <= MaxTxn)
              && ({6'd0, bus.withdraw_value} <= curBalance);
    // The stored PIN of card k is k itself.
    authOk  = (bus.CardNo >= 3'd1) && (bus.CardNo <= MaxCard)
              && (bus.Password == bus.CardNo);
  end

  // Session state machine. The accept pulses default low every cycle, so
  // they can only be high for the single cycle after a DEP/WDR commit.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= IDLE;
      cardNo_q         <= '0;
      unusedLanguage_q <= 1'b0;
      depAccepted_q    <= 1'b0;
      wdrAccepted_q    <= 1'b0;
      display_q        <= '0;
      for (int k = 1; k <= NUM_ACCOUNTS; k++) begin
        balance_q[k] <= InitBal;
      end
    end else begin
      depAccepted_q <= 1'b0;
      wdrAccepted_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.card_inserted) begin
            state_q <= LANG;
          end
        end
        LANG: begin
          unusedLanguage_q <= bus.language_selected;
          state_q          <= AUTH;
        end
        AUTH: begin
          if (authOk) begin
            cardNo_q <= bus.CardNo;
            state_q  <= MENU;
          end else begin
            state_q <= IDLE;
          end
        end
        MENU: begin
          case (bus.request)
            2'd0: begin
              display_q <= curBalance;
            end
            2'd1: begin
              display_q <= curBalance;
              state_q   <= DEP;
            end
            2'd2: begin
              display_q <= curBalance;
              state_q   <= WDR;
            end
            default: begin
              display_q <= '0;
              cardNo_q  <= '0;
              state_q   <= IDLE;
            end
          endcase
        end
        DEP: begin
          if (depOk) begin
            for (int k = 1; k <= NUM_ACCOUNTS; k++) begin
              if (cardNo_q == 3'(k)) begin
                balance_q[k] <= depSum[17:0];
              end
            end
            display_q     <= depSum[17:0];
            depAccepted_q <= 1'b1;
          end
          state_q <= MENU;
        end
        WDR: begin
          if (wdrOk) begin
            for (int k = 1; k <= NUM_ACCOUNTS; k++) begin
              if (cardNo_q == 3'(k)) begin
                balance_q[k] <= wdrDiff;
              end
            end
            display_q     <= wdrDiff;
            wdrAccepted_q <= 1'b1;
          end
          state_q <= MENU;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.deposit_accepted  = depAccepted_q;
  assign bus.withdraw_accepted = wdrAccepted_q;
  assign bus.balance_displayed = display_q;

endmodule

// File: tb/tb_atm_fsm.sv
// ---------------------------------------------------------------------------
// tb_atm_fsm
// Self-checking bench for atm_fsm. Each request pushes its expected pulses
// and displayed balance (from an independent account model) onto a
// scoreboard queue; the entry is popped and compared once the DUT has
// processed the request.
// ---------------------------------------------------------------------------
module tb_atm_fsm;

  localparam int MaxBal = 262143;

  typedef struct {
    string       tag;
    logic        dep;
    logic        wdr;
    logic [17:0] disp;
  } exp_t;

  logic clk;
  logic rst;

  atm_fsm_if bus ();

  atm_fsm #(
    .NUM_ACCOUNTS(5),
    .INIT_BALANCE(1000),
    .MAX_TXN(2000)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  int   checkCount;
  int   errorCount;
  int   modelBal [1:5];
  int   curCard;
  exp_t expQ [$];

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Guard against a run that never reaches its summary.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison point: counts every check, reports any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  // Holds reset for two cycles and checks that all outputs are cleared.
  task automatic resetDut(input string tag);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkOutput({tag, "_dep"},  32'(bus.deposit_accepted), 32'd0);
    checkOutput({tag, "_wdr"},  32'(bus.withdraw_accepted), 32'd0);
    checkOutput({tag, "_disp"}, 32'(bus.balance_displayed), 32'd0);
    rst = 1'b0;
    for (int k = 1; k <= 5; k++) modelBal[k] = 1000;
    curCard = 0;
  endtask

  // Presents a card for one cycle and keeps card/PIN steady until the
  // authentication decision has been taken three rising edges later.
  task automatic startSession(input int card, input int pin, input string tag);
    bus.CardNo            = 3'(card);
    bus.Password          = 3'(pin);
    bus.card_inserted     = 1'b1;
    bus.language_selected = 1'($urandom_range(0, 1));
    @(negedge clk);
    bus.card_inserted = 1'b0;
    @(negedge clk);
    @(negedge clk);
    if (card >= 1 && card <= 5 && pin == card) begin
      curCard = card;
    end else begin
      curCard = 0;
      checkOutput({tag, "_authFailDisp"}, 32'(bus.balance_displayed), 32'd0);
      checkOutput({tag, "_authFailDep"},  32'(bus.deposit_accepted), 32'd0);
    end
  endtask

  // Drives one request for two cycles, then drops back to a balance inquiry
  // and confirms the accept pulse lasted only one cycle.
  task automatic applyStimulus(input logic [1:0] req, input int depVal,
                               input int wdrVal, input string tag);
    exp_t e;
    exp_t got;
    e.tag  = tag;
    e.dep  = 1'b0;
    e.wdr  = 1'b0;
    e.disp = '0;
    if (curCard != 0) begin
      case (req)
        2'd0: e.disp = 18'(modelBal[curCard]);
        2'd1: begin
          if (depVal >= 1 && depVal <= 2000 && modelBal[curCard] + depVal <= MaxBal) begin
            modelBal[curCard] += depVal;
            e.dep = 1'b1;
          end
          e.disp = 18'(modelBal[curCard]);
        end
        2'd2: begin
          if (wdrVal >= 1 && wdrVal <= 2000 && wdrVal <= modelBal[curCard]) begin
            modelBal[curCard] -= wdrVal;
            e.wdr = 1'b1;
          end
          e.disp = 18'(modelBal[curCard]);
        end
        default: begin
          curCard = 0;
          e.disp  = '0;
        end
      endcase
    end
    expQ.push_back(e);

    bus.request        = req;
    bus.deposit_value  = 12'(depVal);
    bus.withdraw_value = 12'(wdrVal);
    @(negedge clk);
    @(negedge clk);

    if (expQ.size() == 0) begin
      checkOutput({tag, "_queueEmpty"}, 32'd0, 32'd1);
    end else begin
      got = expQ.pop_front();
      checkOutput({got.tag, "_dep"},  32'(bus.deposit_accepted),  32'(got.dep));
      checkOutput({got.tag, "_wdr"},  32'(bus.withdraw_accepted), 32'(got.wdr));
      checkOutput({got.tag, "_disp"}, 32'(bus.balance_displayed), 32'(got.disp));
    end

    bus.request        = 2'd0;
    bus.deposit_value  = '0;
    bus.withdraw_value = '0;
    @(negedge clk);
    checkOutput({tag, "_pulseEnd"},
                32'({bus.deposit_accepted, bus.withdraw_accepted}), 32'd0);
  endtask

  initial begin
    checkCount            = 0;
    errorCount            = 0;
    rst                   = 1'b1;
    bus.language_selected = 1'b0;
    bus.card_inserted     = 1'b0;
    bus.request           = 2'd0;
    bus.deposit_value     = '0;
    bus.withdraw_value    = '0;
    bus.CardNo            = '0;
    bus.Password          = '0;

    resetDut("reset");

    // Card 2: a chain of accepted deposits and withdrawals.
    startSession(2, 2, "c2");
    applyStimulus(2'd1, 1000, 0,   "c2_dep1000");
    applyStimulus(2'd2, 0,    800, "c2_wdr800");
    applyStimulus(2'd2, 0,    700, "c2_wdr700");
    applyStimulus(2'd1, 500,  0,   "c2_dep500");
    applyStimulus(2'd2, 0,    600, "c2_wdr600");
    applyStimulus(2'd3, 0,    0,   "c2_exit");

    // Card 3: withdrawal larger than the balance is refused.
    startSession(3, 3, "c3");
    applyStimulus(2'd1, 100,  0,    "c3_dep100");
    applyStimulus(2'd2, 0,    1500, "c3_wdr1500");
    applyStimulus(2'd3, 0,    0,    "c3_exit");

    // Card 4: amounts above the per-transaction limit are refused.
    startSession(4, 4, "c4");
    applyStimulus(2'd1, 3000, 0,    "c4_dep3000");
    applyStimulus(2'd2, 0,    2500, "c4_wdr2500");
    applyStimulus(2'd1, 4000, 0,    "c4_dep4000");
    applyStimulus(2'd0, 0,    0,    "c4_bal");
    applyStimulus(2'd3, 0,    0,    "c4_exit");

    // Card 6 does not exist: no session, requests have no effect.
    startSession(6, 6, "c6");
    applyStimulus(2'd1, 500, 0, "c6_dep500");

    // Wrong PIN on card 1, then a good login and a balance inquiry.
    startSession(1, 2, "c1bad");
    applyStimulus(2'd0, 0, 0, "c1bad_bal");
    startSession(1, 1, "c1");
    applyStimulus(2'd0, 0, 0, "c1_bal");
    applyStimulus(2'd3, 0, 0, "c1_exit");

    // Card 5: amount boundaries and the 18-bit ceiling. The unselected
    // amount field carries junk that must be ignored.
    startSession(5, 5, "c5");
    applyStimulus(2'd1, 0,    4095, "c5_dep0");
    applyStimulus(2'd1, 2000, 4095, "c5_dep2000");
    applyStimulus(2'd2, 4095, 0,    "c5_wdr0");
    applyStimulus(2'd2, 4095, 2000, "c5_wdr2000");
    applyStimulus(2'd2, 0,    1000, "c5_wdrAll");
    applyStimulus(2'd2, 0,    1,    "c5_wdrEmpty");
    for (int i = 0; i < 131; i++) begin
      applyStimulus(2'd1, 2000, int'($urandom_range(0, 4095)), "c5_fill");
    end
    applyStimulus(2'd1, 2000, 0, "c5_depOverflow");
    applyStimulus(2'd1, 143,  0, "c5_depToMax");
    applyStimulus(2'd1, 1,    0, "c5_depPastMax");
    applyStimulus(2'd3, 0,    0, "c5_exit");

    // Card 1: balance persists across sessions; reset aborts and reloads.
    startSession(1, 1, "c1b");
    applyStimulus(2'd1, 500, 0, "c1b_dep500");
    applyStimulus(2'd3, 0,   0, "c1b_exit");
    startSession(1, 1, "c1c");
    applyStimulus(2'd0, 0, 0, "c1c_bal");
    bus.request       = 2'd1;
    bus.deposit_value = 12'd700;
    resetDut("midReset");
    bus.request       = 2'd0;
    bus.deposit_value = '0;
    startSession(1, 1, "c1d");
    applyStimulus(2'd0, 0, 0, "c1d_balReinit");
    applyStimulus(2'd3, 0, 0, "c1d_exit");

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
